psum_buffer_mc: RTL and testbench

- Parametrised successor psum buffer between the PE array column tops and the controller.
- Holds one FIFO per (column, filter) pair. In MODE1 it collects partial sums from the PE columns.
- In MODE2 it replays stored psums to each column, round-robin across a runtime-selected number of active filters, for a programmed number of rounds. It then signals done.
- New versus the previous generation: parametrised shape, runtime filter count, bounded replay with done, explicit FSM, and occupancy outputs.

---
 rtl/psum_buffer_mc_pkg.sv | 29 ++
 rtl/psum_buffer_mc_if.sv | 26 ++
 rtl/psum_buffer_mc_fifo.sv | 57 +++++
 rtl/psum_buffer_mc.sv | 180 ++++++++++++++++++
 tb/tb_psum_buffer_mc.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/psum_buffer_mc_pkg.sv
// Shared types for the psum buffer: operating mode, psum packet and FSM state encoding.
`ifndef PSUM_DATA_SIZE
`define PSUM_DATA_SIZE 16
`endif

package psum_buffer_mc_pkg;

  // Packet filter index is sized for the largest filter count the family supports.
  localparam int PKT_FIDX_W = 4;

  typedef enum logic {
    MODE1 = 1'b0,
    MODE2 = 1'b1
  } OP_MODE;

  typedef struct packed {
    logic                       valid;
    logic [PKT_FIDX_W-1:0]      filter_idx;
    logic [`PSUM_DATA_SIZE-1:0] psum;
  } PSUM_PACKET;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CLEAR   = 2'd1,
    S_COLLECT = 2'd2,
    S_REPLAY  = 2'd3
  } state_t;

endpackage

// File: rtl/psum_buffer_mc_if.sv
// Column-side psum bus: writes from the PE column tops and replay packets back to the columns.
interface psum_buffer_mc_if #(
  parameter int NUM_COL = 7
);
  import psum_buffer_mc_pkg::*;

  PSUM_PACKET         psum_in [NUM_COL];
  logic [NUM_COL-1:0] psum_buffer_ack;
  PSUM_PACKET         psum_out [NUM_COL];
  logic [NUM_COL-1:0] pe_psum_ack;

  modport master (
    output psum_in,
    output pe_psum_ack,
    input  psum_buffer_ack,
    input  psum_out
  );

  modport slave (
    input  psum_in,
    input  pe_psum_ack,
    output psum_buffer_ack,
    output psum_out
  );

endinterface

// File: rtl/psum_buffer_mc_fifo.sv
// Generic first-word-fall-through FIFO with an occupancy count and a synchronous flush.
module psum_buffer_mc_fifo #(
  parameter int DEPTH = 64,
  parameter int W     = 16,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fifo_flush,
  input  logic             push,
  input  logic [W-1:0]     din,
  input  logic             pop,
  output logic [W-1:0]     dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] level
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]     mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CNT_W-1:0] cnt;

  function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] ptr);
    return (ptr == AW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (fifo_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= ptr_next(wr_ptr);
      if (pop)  rd_ptr <= ptr_next(rd_ptr);
      if (push && !pop)      cnt <= cnt + 1'b1;
      else if (pop && !push) cnt <= cnt - 1'b1;
    end
  end

  // Storage carries no reset; occupancy is defined by the pointers alone.
  always_ff @(posedge clk) begin
    if (push && !fifo_flush) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign full  = (cnt == CNT_W'(DEPTH));
  assign empty = (cnt == '0);
  assign level = cnt;

endmodule

// File: rtl/psum_buffer_mc.sv
// Psum buffer between PE column tops and controller: per-(column, filter) FIFOs, collect and bounded replay.
// Define PSUM_BUF_STATS_EN to add the drop_sticky / drop_cnt statistics outputs.
//
// state     | meaning
// S_IDLE    | waiting for start_conv
// S_CLEAR   | one-cycle flush of every FIFO before collecting
// S_COLLECT | accepting psum writes from the columns
// S_REPLAY  | round-robin replay per column until every column has done its rounds
module psum_buffer_mc
  import psum_buffer_mc_pkg::*;
#(
  parameter int NUM_COL    = 7,
  parameter int NUM_FILTER = 4,
  parameter int DEPTH      = 64,
  parameter int DATA_W     = `PSUM_DATA_SIZE,
  parameter int FIDX_W     = $clog2(NUM_FILTER),
  parameter int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start_conv,
  input  OP_MODE                   mode_in,
  input  logic [FIDX_W:0]          num_filter_in,
  input  logic [CNT_W-1:0]         replay_rounds_in,
  psum_buffer_mc_if.slave          bus,
  output logic                     busy,
  output logic                     done,
  output logic [NUM_COL*CNT_W-1:0] col_level
`ifdef PSUM_BUF_STATS_EN
  ,
  output logic                     drop_sticky,
  output logic [15:0]              drop_cnt
`endif
);

  localparam int NQ = NUM_COL * NUM_FILTER;

  state_t           state;
  logic [FIDX_W:0]  nf;
  logic [CNT_W-1:0] rounds;
  logic [FIDX_W-1:0] ptr [NUM_COL];
  logic [CNT_W-1:0] round_cnt [NUM_COL];

  logic [NQ-1:0]     push_q, pop_q, full_q, empty_q;
  logic [DATA_W-1:0] dout_q [NQ];
  logic [CNT_W-1:0]  lvl_q  [NQ];

  logic [NUM_COL-1:0] ack, adv, fin;
  logic               wr_en, all_fin, start_acc;
  PSUM_PACKET         out_pkt [NUM_COL];

  for (genvar c = 0; c < NUM_COL; c++) begin : g_col
    for (genvar f = 0; f < NUM_FILTER; f++) begin : g_flt
      psum_buffer_mc_fifo #(
        .DEPTH (DEPTH),
        .W     (DATA_W),
        .CNT_W (CNT_W)
      ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .fifo_flush (state == S_CLEAR),
        .push       (push_q[c*NUM_FILTER+f]),
        .din        (bus.psum_in[c].psum),
        .pop        (pop_q[c*NUM_FILTER+f]),
        .dout       (dout_q[c*NUM_FILTER+f]),
        .full       (full_q[c*NUM_FILTER+f]),
        .empty      (empty_q[c*NUM_FILTER+f]),
        .level      (lvl_q[c*NUM_FILTER+f])
      );
    end
  end

  always_comb begin
    wr_en     = (state == S_COLLECT) || (state == S_REPLAY);
    start_acc = start_conv && ((state == S_IDLE) || (state == S_COLLECT));
    ack       = '0;
    adv       = '0;
    fin       = '0;
    push_q    = '0;
    pop_q     = '0;
    all_fin   = 1'b1;
    col_level = '0;
    for (int c = 0; c < NUM_COL; c++) begin
      out_pkt[c] = '0;
      // Filters at or beyond the active count are never accepted.
      for (int f = 0; f < NUM_FILTER; f++) begin
        if (wr_en && bus.psum_in[c].valid && (int'(bus.psum_in[c].filter_idx) == f) &&
            (f < int'(nf)) && !full_q[c*NUM_FILTER+f]) begin
          push_q[c*NUM_FILTER+f] = 1'b1;
          ack[c]                 = 1'b1;
        end
      end
      fin[c]                = (round_cnt[c] == rounds);
      all_fin               = all_fin & fin[c];
      out_pkt[c].valid      = (state == S_REPLAY) && !empty_q[c*NUM_FILTER+int'(ptr[c])] && !fin[c];
      out_pkt[c].filter_idx = PKT_FIDX_W'(ptr[c]);
      out_pkt[c].psum       = dout_q[c*NUM_FILTER+int'(ptr[c])];
      adv[c]                = out_pkt[c].valid && bus.pe_psum_ack[c];
      pop_q[c*NUM_FILTER+int'(ptr[c])] = adv[c];
      col_level[c*CNT_W +: CNT_W]      = lvl_q[c*NUM_FILTER+int'(ptr[c])];
    end
  end

  assign bus.psum_buffer_ack = ack;
  assign bus.psum_out        = out_pkt;
  assign busy                = (state != S_IDLE);
  assign done                = (state == S_REPLAY) && all_fin;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      nf     <= '0;
      rounds <= '0;
      for (int c = 0; c < NUM_COL; c++) begin
        ptr[c]       <= '0;
        round_cnt[c] <= '0;
      end
    end else begin
      case (state)
        S_IDLE, S_COLLECT: begin
          if (start_conv) begin
            nf     <= num_filter_in;
            rounds <= replay_rounds_in;
            if (mode_in == MODE2) begin
              state <= S_REPLAY;
              for (int c = 0; c < NUM_COL; c++) begin
                ptr[c]       <= '0;
                round_cnt[c] <= '0;
              end
            end else begin
              state <= S_CLEAR;
            end
          end
        end
        S_CLEAR: state <= S_COLLECT;
        S_REPLAY: begin
          for (int c = 0; c < NUM_COL; c++) begin
            if (adv[c]) begin
              if ({1'b0, ptr[c]} == nf - 1'b1) begin
                ptr[c]       <= '0;
                round_cnt[c] <= round_cnt[c] + 1'b1;
              end else begin
                ptr[c] <= ptr[c] + 1'b1;
              end
            end
          end
          if (all_fin) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef PSUM_BUF_STATS_EN
  logic [NUM_COL-1:0] drop;
  logic [16:0]        drop_sum;

  always_comb begin
    drop = '0;
    for (int c = 0; c < NUM_COL; c++) begin
      drop[c] = wr_en && bus.psum_in[c].valid && !ack[c];
    end
    drop_sum = {1'b0, drop_cnt} + 17'($countones(drop));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_sticky <= 1'b0;
      drop_cnt    <= '0;
    end else if (start_acc) begin
      drop_sticky <= 1'b0;
      drop_cnt    <= '0;
    end else if (|drop) begin
      drop_sticky <= 1'b1;
      drop_cnt    <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end
`endif

endmodule

// File: tb/tb_psum_buffer_mc.sv
// Scoreboard bench for psum_buffer_mc: directed collect/replay vectors, monitor compares every replay handshake.
module tb_psum_buffer_mc;
  import psum_buffer_mc_pkg::*;

  localparam int NUM_COL    = 7;
  localparam int NUM_FILTER = 4;
  localparam int DEPTH      = 4;
  localparam int FIDX_W     = 2;
  localparam int CNT_W      = 3;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic                     start_conv = 1'b0;
  OP_MODE                   mode_in = MODE1;
  logic [FIDX_W:0]          num_filter_in = '0;
  logic [CNT_W-1:0]         replay_rounds_in = '0;
  logic                     busy, done;
  logic [NUM_COL*CNT_W-1:0] col_level;
`ifdef PSUM_BUF_STATS_EN
  logic                     drop_sticky;
  logic [15:0]              drop_cnt;
`endif

  psum_buffer_mc_if #(.NUM_COL(NUM_COL)) bus ();

  psum_buffer_mc #(
    .NUM_COL    (NUM_COL),
    .NUM_FILTER (NUM_FILTER),
    .DEPTH      (DEPTH)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start_conv       (start_conv),
    .mode_in          (mode_in),
    .num_filter_in    (num_filter_in),
    .replay_rounds_in (replay_rounds_in),
    .bus              (bus),
    .busy             (busy),
    .done             (done),
    .col_level        (col_level)
`ifdef PSUM_BUF_STATS_EN
    ,
    .drop_sticky      (drop_sticky),
    .drop_cnt         (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  int         n_vec = 0;
  int         n_err = 0;
  int         done_seen = 0;
  int         col_pops [NUM_COL];
  logic [19:0] exp_q [NUM_COL][$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [NUM_COL-1:0] vmask();
    logic [NUM_COL-1:0] v;
    for (int c = 0; c < NUM_COL; c++) v[c] = bus.psum_out[c].valid;
    return v;
  endfunction

  function automatic logic [CNT_W-1:0] lvl(input int c);
    return col_level[c*CNT_W +: CNT_W];
  endfunction

  // Monitor: every accepted replay packet is checked against the column's expected queue.
  initial begin
    for (int c = 0; c < NUM_COL; c++) col_pops[c] = 0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (done) done_seen++;
        for (int c = 0; c < NUM_COL; c++) begin
          if (bus.psum_out[c].valid && bus.pe_psum_ack[c]) begin
            col_pops[c]++;
            if (exp_q[c].size() == 0) begin
              check($sformatf("col%0d_unexpected_out", c),
                    32'({bus.psum_out[c].filter_idx, bus.psum_out[c].psum}), 32'hFFFF_FFFF);
            end else begin
              check($sformatf("col%0d_out", c),
                    32'({bus.psum_out[c].filter_idx, bus.psum_out[c].psum}),
                    32'(exp_q[c].pop_front()));
            end
          end
        end
      end
    end
  end

  task automatic start(input OP_MODE m, input logic [FIDX_W:0] nfv, input logic [CNT_W-1:0] rnd);
    @(posedge clk); #1;
    start_conv       = 1'b1;
    mode_in          = m;
    num_filter_in    = nfv;
    replay_rounds_in = rnd;
    @(posedge clk); #1;
    start_conv = 1'b0;
  endtask

  // One write/ack cycle on all selected columns; column c carries psum d0 + 16*c.
  task automatic step(input logic [NUM_COL-1:0] wr_mask, input logic [3:0] f, input logic [15:0] d0,
                      input logic [NUM_COL-1:0] ack_mask, input logic [NUM_COL-1:0] exp_ack,
                      input string name);
    logic [15:0] d;
    @(posedge clk); #1;
    for (int c = 0; c < NUM_COL; c++) begin
      bus.psum_in[c].valid      = wr_mask[c];
      bus.psum_in[c].filter_idx = f;
      bus.psum_in[c].psum       = d0 + 16'(c * 16);
    end
    bus.pe_psum_ack = ack_mask;
    @(negedge clk);
    check(name, 32'(bus.psum_buffer_ack), 32'(exp_ack));
    for (int c = 0; c < NUM_COL; c++) begin
      d = d0 + 16'(c * 16);
      if (exp_ack[c]) exp_q[c].push_back({f, d});
    end
    @(posedge clk); #1;
    for (int c = 0; c < NUM_COL; c++) bus.psum_in[c].valid = 1'b0;
    bus.pe_psum_ack = '0;
  endtask

  task automatic wait_done(input int budget, input string name);
    bit seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check({name, "_done_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      check({name, "_busy_at_done"}, 32'(busy), 32'd1);
      @(negedge clk);
      check({name, "_busy_after"}, 32'(busy), 32'd0);
      check({name, "_done_one_cycle"}, 32'(done), 32'd0);
    end
    bus.pe_psum_ack = '0;
  endtask

  task automatic check_drained(input string name);
    for (int c = 0; c < NUM_COL; c++)
      check($sformatf("%s_col%0d_left", name, c), 32'(exp_q[c].size()), 32'd0);
  endtask

  initial begin
    for (int c = 0; c < NUM_COL; c++) begin
      bus.psum_in[c].valid      = 1'b1;
      bus.psum_in[c].filter_idx = '0;
      bus.psum_in[c].psum       = '0;
    end
    bus.pe_psum_ack = '1;

    // Reset state
    #2;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ack", 32'(bus.psum_buffer_ack), 32'd0);
    check("rst_valid", 32'(vmask()), 32'd0);
    check("rst_level", 32'(col_level), 32'd0);
    #10;
    for (int c = 0; c < NUM_COL; c++) bus.psum_in[c].valid = 1'b0;
    bus.pe_psum_ack = '0;
    rst_n = 1'b1;

    // Collect/replay basic: nf=4, 8 writes per column, 2 rounds
    start(MODE1, 3'd4, 3'd0);
    for (int i = 0; i < 8; i++)
      step('1, 4'(i % 4), 16'(i + 1), '0, '1, "t1_wr_ack");
    check("t1_level_c0", 32'(lvl(0)), 32'd2);
    start(MODE2, 3'd4, 3'd2);
    bus.pe_psum_ack = '1;
    wait_done(50, "t1");
    check("t1_done_count", 32'(done_seen), 32'd1);
    check_drained("t1");

    // Runtime filter count: nf=2, filters 2 and 3 refused
    start(MODE1, 3'd2, 3'd0);
    step('1, 4'd3, 16'h100, '0, '0, "t2_wr_f3_refused");
    step('1, 4'd0, 16'h200, '0, '1, "t2_wr_f0");
    step('1, 4'd1, 16'h300, '0, '1, "t2_wr_f1");
    step('1, 4'd2, 16'h400, '0, '0, "t2_wr_f2_refused");
    check("t2_level_c1", 32'(lvl(1)), 32'd1);
    start(MODE2, 3'd2, 3'd1);
    bus.pe_psum_ack = '1;
    wait_done(50, "t2");
    check("t2_done_count", 32'(done_seen), 32'd2);
    check_drained("t2");

    // Full FIFO, then pop and simultaneous pop+write (nf=1 keeps the pointer on filter 0)
    start(MODE1, 3'd1, 3'd0);
    for (int i = 0; i < 4; i++)
      step('1, 4'd0, 16'(16'h500 + i), '0, '1, "t3_wr_fill");
    step('1, 4'd0, 16'h5F0, '0, '0, "t3_wr_full_refused");
    check("t3_level_full", 32'(lvl(2)), 32'd4);
    start(MODE2, 3'd1, 3'd5);
    check("t3_valid_on_entry", 32'(vmask()), 32'h7F);
    step('0, 4'd0, 16'h0, '1, '0, "t3_pop_only");
    check("t3_level_after_pop", 32'(lvl(2)), 32'd3);
    step('1, 4'd0, 16'h600, '1, '1, "t3_pop_and_write");
    check("t3_level_unchanged", 32'(lvl(2)), 32'd3);
    bus.pe_psum_ack = '1;
    wait_done(50, "t3");
    check("t3_done_count", 32'(done_seen), 32'd3);
    check_drained("t3");

    // Stall on empty filter 1; acks while invalid do not move the pointer
    start(MODE1, 3'd2, 3'd0);
    step('1, 4'd0, 16'h700, '0, '1, "t4_wr_f0");
    start(MODE2, 3'd2, 3'd1);
    bus.pe_psum_ack = '1;
    repeat (4) @(negedge clk);
    check("t4_stalled_valid", 32'(vmask()), 32'd0);
    check("t4_ptr_held", 32'(bus.psum_out[0].filter_idx), 32'd1);
    check("t4_busy_stalled", 32'(busy), 32'd1);
    step('1, 4'd1, 16'h800, '1, '1, "t4_wr_f1");
    check("t4_valid_after_push", 32'(vmask()), 32'h7F);
    check("t4_ptr_still_1", 32'(bus.psum_out[6].filter_idx), 32'd1);
    bus.pe_psum_ack = '1;
    wait_done(50, "t4");
    check("t4_done_count", 32'(done_seen), 32'd4);
    check_drained("t4");

    // Columns out of step: column 6 acks every third cycle, rounds=3
    start(MODE1, 3'd4, 3'd0);
    for (int i = 0; i < 12; i++)
      step('1, 4'(i % 4), 16'(16'h900 + i), '0, '1, "t5_wr_ack");
    for (int c = 0; c < NUM_COL; c++) col_pops[c] = 0;
    start(MODE2, 3'd4, 3'd3);
    begin
      bit seen = 1'b0;
      for (int cyc = 0; cyc < 200; cyc++) begin
        @(posedge clk); #1;
        bus.pe_psum_ack    = '1;
        bus.pe_psum_ack[6] = ((cyc % 3) == 0);
        @(negedge clk);
        if (done) begin
          seen = 1'b1;
          check("t5_col6_pops_at_done", 32'(col_pops[6]), 32'd12);
          check("t5_col0_pops_at_done", 32'(col_pops[0]), 32'd12);
          break;
        end
      end
      check("t5_done_seen", 32'(seen), 32'd1);
      @(negedge clk);
      check("t5_busy_after", 32'(busy), 32'd0);
    end
    bus.pe_psum_ack = '0;
    check("t5_done_count", 32'(done_seen), 32'd5);
    check_drained("t5");

    // Reset mid-replay, then replay on empty FIFOs stalls without done
    start(MODE1, 3'd1, 3'd0);
    step('1, 4'd0, 16'hA00, '0, '1, "t6_wr");
    start(MODE2, 3'd1, 3'd3);
    check("t6_busy_replay", 32'(busy), 32'd1);
    check("t6_valid_replay", 32'(vmask()), 32'h7F);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", 32'(vmask()), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_done", 32'(done), 32'd0);
    for (int c = 0; c < NUM_COL; c++) exp_q[c].delete();
    @(negedge clk);
    rst_n = 1'b1;
    start(MODE2, 3'd4, 3'd1);
    bus.pe_psum_ack = '1;
    repeat (10) @(negedge clk);
    check("t6_empty_valid", 32'(vmask()), 32'd0);
    check("t6_empty_busy", 32'(busy), 32'd1);
    check("t6_no_done", 32'(done_seen), 32'd5);
    bus.pe_psum_ack = '0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, vectors %0d", n_vec);
    $fatal(1, "watchdog");
  end

endmodule
